// File: rtl/multicycle_controller_if.sv
// Datapath control bundle between the multi-cycle sequencer (master) and the
// datapath/memory side (slave).
interface multicycle_controller_if;
  logic       run;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_sel;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       alu_src;
  logic       mem_to_reg;
  logic       imm_sel;
  logic       busy;
  logic [1:0] fault;

  modport master (
    input  run, opcode, mem_ready,
    output mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write,
           alu_src, mem_to_reg, imm_sel, busy, fault
  );

  modport slave (
    output run, opcode, mem_ready,
    input  mem_req, mem_we, mem_sel, ir_write, pc_write, reg_write,
           alu_src, mem_to_reg, imm_sel, busy, fault
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with req/ready memory handshake and
// sticky illegal-opcode / memory-timeout faults. Optional retired-instruction counter: PERF_CNT_EN.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0]         instr_count,
`endif
  multicycle_controller_if.master  bus
);

  // state  | meaning
  // IDLE   | waiting for run | FETCH  instruction read | DECODE classify opcode
  // EXEC   | ALU setup       | MEM    data access      | WB writeback, PC advance
  // FAULT  | sticky error, left only through rst_n
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  typedef enum logic [1:0] {C_LOAD, C_STORE, C_OP, C_OPIMM} cls_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       fault_q, fault_d;

  logic mem_req_q, mem_we_q, mem_sel_q, reg_write_q, alu_src_q;
  logic mem_to_reg_q, imm_sel_q, busy_q, wb_q;

  // Wait counter restarts from zero on every state change, so entering FETCH/MEM clears it.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    fault_d = fault_q;
    tmo_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (bus.opcode)
          OPC_LOAD:  cls_d = C_LOAD;
          OPC_STORE: cls_d = C_STORE;
          OPC_OP:    cls_d = C_OP;
          OPC_OPIMM: cls_d = C_OPIMM;
          default: begin
            state_d = S_FAULT;
            fault_d = 2'b01;
          end
        endcase
      end
      S_EXEC: begin
        state_d = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (cls_q == C_STORE) state_d = bus.run ? S_FETCH : S_IDLE;
          else                  state_d = S_WB;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state. ALU operand selects stay up
  // through WB so the ALU result being written back remains stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cls_q        <= C_LOAD;
      tmo_q        <= '0;
      fault_q      <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      imm_sel_q    <= 1'b0;
      busy_q       <= 1'b0;
      wb_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      tmo_q        <= tmo_d;
      fault_q      <= fault_d;
      mem_req_q    <= (state_d == S_FETCH) || (state_d == S_MEM);
      mem_sel_q    <= (state_d == S_MEM);
      mem_we_q     <= (state_d == S_MEM) && (cls_d == C_STORE);
      alu_src_q    <= ((state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB))
                      && (cls_d != C_OP);
      imm_sel_q    <= ((state_d == S_EXEC) || (state_d == S_MEM)) && (cls_d == C_STORE);
      reg_write_q  <= (state_d == S_WB);
      mem_to_reg_q <= (state_d == S_WB) && (cls_d == C_LOAD);
      wb_q         <= (state_d == S_WB);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_FAULT);
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_sel    = mem_sel_q;
  assign bus.ir_write   = mem_req_q && !mem_sel_q && bus.mem_ready;
  assign bus.pc_write   = wb_q || (mem_we_q && bus.mem_ready);
  assign bus.reg_write  = reg_write_q;
  assign bus.alu_src    = alu_src_q;
  assign bus.mem_to_reg = mem_to_reg_q;
  assign bus.imm_sel    = imm_sel_q;
  assign bus.busy       = busy_q;
  assign bus.fault      = fault_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt_q <= '0;
    else if (bus.pc_write) cnt_q <= cnt_q + 1'b1;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: a per-cycle expectation table built from instruction-level rules
// (phase lengths, waits, strobes) is compared against the controller every cycle.
module tb_multicycle_controller;
  localparam int NMAX = 8192;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_BAD   = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

`ifdef PERF_CNT_EN
  logic [3:0] instr_count;
  multicycle_controller #(.TIMEOUT_CYCLES(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_count(instr_count), .bus(bus.master));
`else
  multicycle_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master));
`endif

  int total = 0;
  int fails = 0;

  logic        run_a [NMAX];
  logic [6:0]  opc_a [NMAX];
  logic        rdy_a [NMAX];
  logic [11:0] exp_a [NMAX];
`ifdef PERF_CNT_EN
  logic [3:0]  cnt_a [NMAX];
  int          pcw_total;
`endif
  int n, limit, cur;
  bit chk_en = 1'b0;
  bit in_idle, dead;
  int first_req, last_req, last_pcw, pcw_seen;

  task automatic chk(input string name, input int t, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, t, act, exp);
    end
  endtask

  function automatic logic [11:0] dut_vec();
    return {bus.mem_req, bus.mem_we, bus.mem_sel, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.alu_src, bus.mem_to_reg, bus.imm_sel, bus.busy, bus.fault};
  endfunction

  function automatic logic [11:0] mk(input logic req, we, sel, irw, pcw, rw, alus, m2r,
                                     imms, bsy, input logic [1:0] f);
    return {req, we, sel, irw, pcw, rw, alus, m2r, imms, bsy, f};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  task automatic push(input logic r, input logic [6:0] o, input logic rd, input logic [11:0] e);
    if (n >= limit || n >= NMAX) return;
    run_a[n] = r;
    opc_a[n] = o;
    rdy_a[n] = rd;
    exp_a[n] = e;
`ifdef PERF_CNT_EN
    cnt_a[n] = pcw_total[3:0];
    if (e[7]) pcw_total++;
`endif
    n++;
  endtask

  task automatic fault_tail(input logic [1:0] f);
    repeat (3) push(rb(), ro(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                         1'b0, 1'b0, f));
    dead = 1'b1;
  endtask

  // One instruction: fw/mw are memory wait cycles before ready (>=16 means never ready).
  task automatic gen_instr(input logic [6:0] opc, input int fw, input int mw, input logic b2b);
    logic ld, st, op, legal, alus;
    ld    = (opc == OPC_LOAD);
    st    = (opc == OPC_STORE);
    op    = (opc == OPC_OP);
    legal = ld | st | op | (opc == OPC_OPIMM);
    alus  = legal & !op;
    if (dead) return;
    if (in_idle) begin
      repeat ($urandom_range(0, 2)) push(1'b0, ro(), rb(), 12'h000);
      push(1'b1, ro(), rb(), 12'h000);
    end
    for (int i = 0; i < fw && i < 16; i++)
      push(rb(), ro(), 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    if (fw >= 16) begin fault_tail(2'b10); return; end
    push(rb(), ro(), 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    push(rb(), opc, rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    if (!legal) begin fault_tail(2'b01); return; end
    push(rb(), ro(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, alus, 1'b0, st, 1'b1, 2'b00));
    if (ld | st) begin
      for (int i = 0; i < mw && i < 16; i++)
        push(rb(), ro(), 1'b0, mk(1'b1, st, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st, 1'b1, 2'b00));
      if (mw >= 16) begin fault_tail(2'b10); return; end
      if (st) begin
        push(b2b, ro(), 1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00));
        in_idle = !b2b;
        return;
      end
      push(rb(), ro(), 1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
    end
    push(b2b, ro(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, alus, ld, 1'b0, 1'b1, 2'b00));
    in_idle = !b2b;
  endtask

  task automatic new_seg();
    n       = 0;
    limit   = NMAX;
    in_idle = 1'b1;
    dead    = 1'b0;
`ifdef PERF_CNT_EN
    pcw_total = 0;
`endif
  endtask

  task automatic run_seg();
    if (!dead) repeat (2) push(1'b0, ro(), rb(), 12'h000);
    chk_en        = 1'b0;
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = 7'd0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", -1, {20'b0, dut_vec()}, 32'h0);
`ifdef PERF_CNT_EN
    chk("reset_count", -1, {28'b0, instr_count}, 32'h0);
`endif
    rst_n     = 1'b1;
    first_req = -1;
    last_req  = -1;
    last_pcw  = -1;
    pcw_seen  = 0;
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      bus.run       = run_a[t];
      bus.opcode    = opc_a[t];
      bus.mem_ready = rdy_a[t];
      cur           = t;
      chk_en        = 1'b1;
      @(negedge clk);
      #2;
    end
    chk_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs", cur, {20'b0, dut_vec()}, {20'b0, exp_a[cur]});
`ifdef PERF_CNT_EN
      chk("instr_count", cur, {28'b0, instr_count}, {28'b0, cnt_a[cur]});
`endif
      if (bus.mem_req) begin
        if (first_req < 0) first_req = cur;
        last_req = cur;
      end
      if (bus.pc_write) begin
        last_pcw = cur;
        pcw_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal_ops [4];
    legal_ops[0] = OPC_LOAD;
    legal_ops[1] = OPC_STORE;
    legal_ops[2] = OPC_OP;
    legal_ops[3] = OPC_OPIMM;
    bus.run       = 1'b0;
    bus.opcode    = 7'd0;
    bus.mem_ready = 1'b0;

    new_seg(); gen_instr(OPC_OP, 0, 0, 1'b0); run_seg();
    chk("alu_latency", 0, last_pcw - first_req + 1, 4);

    new_seg(); gen_instr(OPC_LOAD, 3, 3, 1'b0); run_seg();
    chk("load_latency", 0, last_pcw - first_req + 1, 11);

    new_seg(); gen_instr(OPC_STORE, 0, 2, 1'b0); run_seg();
    chk("store_latency", 0, last_pcw - first_req + 1, 6);

    new_seg(); gen_instr(OPC_BAD, 0, 0, 1'b0); run_seg();
    chk("illegal_fault", 0, {30'b0, bus.fault}, 32'h1);
    chk("illegal_busy", 0, {31'b0, bus.busy}, 32'h0);

    new_seg(); gen_instr(OPC_OP, 16, 0, 1'b0); run_seg();
    chk("timeout_fault", 0, {30'b0, bus.fault}, 32'h2);
    chk("timeout_req_cycles", 0, last_req - first_req + 1, 16);

    new_seg(); gen_instr(OPC_LOAD, 15, 15, 1'b0); run_seg();
    chk("edge_ready_fault", 0, {30'b0, bus.fault}, 32'h0);
    chk("edge_ready_latency", 0, last_pcw - first_req + 1, 35);

    new_seg(); gen_instr(OPC_STORE, 1, 16, 1'b0); run_seg();
    chk("mem_timeout_fault", 0, {30'b0, bus.fault}, 32'h2);

    // Stop the table two wait cycles into the load's MEM phase, then pull reset.
    new_seg();
    in_idle = 1'b0;
    push(1'b0, ro(), rb(), 12'h000);
    push(1'b1, ro(), rb(), 12'h000);
    limit = n + 6;
    gen_instr(OPC_LOAD, 1, 5, 1'b0);
    limit = NMAX;
    dead  = 1'b1;
    run_seg();
    chk("mid_mem_sel", 0, {31'b0, bus.mem_sel}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_mem", 0, {20'b0, dut_vec()}, 32'h0);
    @(posedge clk);
    #1;
    chk("reset_hold", 0, {20'b0, dut_vec()}, 32'h0);

    new_seg();
    for (int i = 0; i < 17; i++)
      gen_instr((i % 2 == 0) ? OPC_OP : OPC_OPIMM, 0, 0, (i < 16) ? 1'b1 : 1'b0);
    run_seg();
    chk("burst_retired", 0, pcw_seen, 17);
`ifdef PERF_CNT_EN
    chk("burst_count_wrap", 0, {28'b0, instr_count}, 32'h1);
`endif

    for (int s = 0; s < 3; s++) begin
      new_seg();
      for (int i = 0; i < 40; i++) begin
        int fw, mw;
        fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
        mw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
        gen_instr(legal_ops[$urandom_range(0, 3)], fw, mw, (i < 39) ? rb() : 1'b0);
      end
      if (s == 2) gen_instr(OPC_BAD, $urandom_range(0, 3), 0, 1'b0);
      run_seg();
    end
    chk("random_final_fault", 0, {30'b0, bus.fault}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end
endmodule
